// File: rtl/conv_bram_ctrl_if.sv
// Stream and BRAM-port bundle for conv_bram_ctrl: fill stream in, replay stream out,
// single-port BRAM control. master = controller side, slave = environment side.
interface conv_bram_ctrl_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 4
);
   logic [DATA_W-1:0] s_tdata;
   logic              s_tvalid;
   logic              s_tready;
   logic              s_tlast;

   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;

   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;
   logic              bram_we;
   logic              bram_en;
   logic [DATA_W-1:0] bram_dout;

   modport master (
      input  s_tdata, s_tvalid, s_tlast, m_tready, bram_dout,
      output s_tready, m_tdata, m_tvalid, m_tlast, bram_addr, bram_din, bram_we, bram_en
   );

   modport slave (
      output s_tdata, s_tvalid, s_tlast, m_tready, bram_dout,
      input  s_tready, m_tdata, m_tvalid, m_tlast, bram_addr, bram_din, bram_we, bram_en
   );
endinterface

// File: rtl/conv_bram_ctrl.sv
// Fill/replay sequencer for one single-port BRAM: loads a tile from the fill stream,
// then replays it for a number of passes through a 2-entry buffer that hides read latency.
module conv_bram_ctrl #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 11,
   parameter int ADDR_W = 4,
   parameter int LEN_W  = 4,
   parameter int PASS_W = 8
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              start,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [PASS_W-1:0] cfg_passes,
   output logic              busy,
   output logic              done,
   output logic              err_short,
   conv_bram_ctrl_if.master  bus
);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

   state_t            state_q;
   logic [LEN_W-1:0]  len_q, eff_len_q, wr_ptr_q, rd_ptr_q;
   logic [PASS_W-1:0] passes_q, pass_cnt_q;
   logic              s_tready_q, busy_q, done_q, err_q;
   logic              issued_all_q, inflight_q, rd_last_q;
   logic [DATA_W-1:0] head_data_q, tail_data_q;
   logic              head_vld_q, head_last_q, tail_vld_q, tail_last_q;

   logic              s_fire, wr_final, rd_wrap, pop, push, rd_issue, drain_end;
   logic [1:0]        occ;
   logic [LEN_W-1:0]  wr_ptr_d;

   always_comb begin
      s_fire   = (state_q == FILL) && s_tready_q && bus.s_tvalid;
      wr_final = s_fire && ((wr_ptr_q == len_q - LEN_W'(1)) || bus.s_tlast);
      wr_ptr_d = wr_ptr_q + LEN_W'(1);
      rd_wrap  = (rd_ptr_q == eff_len_q - LEN_W'(1));
      pop      = head_vld_q && bus.m_tready;
      push     = inflight_q;
      // Occupancy after this cycle's pop, so a read can be issued into the slot
      // being vacated; this is what keeps the stream bubble-free.
      occ      = {1'b0, head_vld_q} + {1'b0, tail_vld_q} - {1'b0, pop};
      rd_issue = (state_q == DRAIN) && !issued_all_q && ((occ + {1'b0, inflight_q}) < 2'd2);
      drain_end = (state_q == DRAIN) && issued_all_q && !inflight_q && (occ == 2'd0);
   end

   assign bus.bram_en   = s_fire || rd_issue;
   assign bus.bram_we   = s_fire;
   assign bus.bram_addr = s_fire   ? wr_ptr_q[ADDR_W-1:0] :
                          rd_issue ? rd_ptr_q[ADDR_W-1:0] : '0;
   assign bus.bram_din  = s_fire ? bus.s_tdata : '0;

   assign bus.s_tready = s_tready_q;
   assign bus.m_tdata  = head_data_q;
   assign bus.m_tvalid = head_vld_q;
   assign bus.m_tlast  = head_last_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err_short    = err_q;

   always_ff @(posedge clka or negedge rsta) begin
      if (!rsta) begin
         state_q      <= IDLE;
         len_q        <= '0;
         eff_len_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         passes_q     <= '0;
         pass_cnt_q   <= '0;
         s_tready_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         issued_all_q <= 1'b0;
         inflight_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         head_data_q  <= '0;
         head_vld_q   <= 1'b0;
         head_last_q  <= 1'b0;
         tail_data_q  <= '0;
         tail_vld_q   <= 1'b0;
         tail_last_q  <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= rd_issue;
         rd_last_q  <= rd_issue && rd_wrap;

         // Head register feeds the output; tail only fills while the head is stalled.
         if (!head_vld_q || pop) begin
            if (tail_vld_q) begin
               head_data_q <= tail_data_q;
               head_last_q <= tail_last_q;
               head_vld_q  <= 1'b1;
               tail_vld_q  <= push;
               if (push) begin
                  tail_data_q <= bus.bram_dout;
                  tail_last_q <= rd_last_q;
               end
            end else begin
               head_vld_q  <= push;
               head_last_q <= push && rd_last_q;
               if (push) head_data_q <= bus.bram_dout;
            end
         end else if (push) begin
            tail_vld_q  <= 1'b1;
            tail_data_q <= bus.bram_dout;
            tail_last_q <= rd_last_q;
         end

         case (state_q)
            IDLE: begin
               if (start) begin
                  len_q        <= (cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;
                  passes_q     <= cfg_passes;
                  err_q        <= 1'b0;
                  wr_ptr_q     <= '0;
                  rd_ptr_q     <= '0;
                  pass_cnt_q   <= '0;
                  issued_all_q <= 1'b0;
                  busy_q       <= 1'b1;
                  if ((cfg_len == '0) || (cfg_passes == '0)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= FILL;
                     s_tready_q <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (s_fire) begin
                  wr_ptr_q <= wr_ptr_d;
                  if (wr_final) begin
                     s_tready_q <= 1'b0;
                     eff_len_q  <= wr_ptr_d;
                     if (bus.s_tlast && (wr_ptr_d < len_q)) err_q <= 1'b1;
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (rd_issue) begin
                  if (rd_wrap) begin
                     rd_ptr_q <= '0;
                     if (pass_cnt_q == passes_q - PASS_W'(1)) issued_all_q <= 1'b1;
                     else pass_cnt_q <= pass_cnt_q + PASS_W'(1);
                  end else begin
                     rd_ptr_q <= rd_ptr_q + LEN_W'(1);
                  end
               end
               if (drain_end) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/conv_bram_ctrl.md
Name: conv_bram_ctrl

Overview:
- Sequencer in front of one conv_bram instance (64-bit, 11-entry, LOW_LATENCY, 1-cycle read).
- Fills the BRAM from an upstream valid/ready stream (DMA weights or feature tile), then replays the stored words to the downstream MAC array as a valid/ready stream for a programmable number of passes.
- Hides the BRAM read latency behind a 2-entry output buffer. Sustains 1 word/cycle while m_tready is high.

Parameters:
- DATA_W, 64, word width; equals the BRAM RAM_WIDTH.
- DEPTH, 11, BRAM entries; equals the BRAM RAM_DEPTH.
- ADDR_W, 4, BRAM address width, clog2(DEPTH).
- LEN_W, 4, cfg_len width; must hold the value DEPTH.
- PASS_W, 8, cfg_passes width.

Ports:
- clka  in  1  clock
- rsta  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; latches cfg_len and cfg_passes
- cfg_len  in  LEN_W  words to load, 1..DEPTH
- cfg_passes  in  PASS_W  replay count
- busy  out  1  high whenever state != IDLE
- done  out  1  1-cycle pulse at end of job
- err_short  out  1  sticky; s_tlast arrived before cfg_len words; cleared by next accepted start
- s_tdata  in  DATA_W  fill stream data
- s_tvalid  in  1  fill stream valid
- s_tready  out  1  fill stream ready
- s_tlast  in  1  fill stream end marker
- m_tdata  out  DATA_W  replay stream data
- m_tvalid  out  1  replay stream valid
- m_tready  in  1  replay stream ready
- m_tlast  out  1  high on the last word of each pass
- bram_addr  out  ADDR_W  to BRAM addra
- bram_din  out  DATA_W  to BRAM dina
- bram_we  out  1  to BRAM wea
- bram_en  out  1  to BRAM ena
- bram_dout  in  DATA_W  from BRAM douta; valid 1 cycle after a read with en=1, we=0

Behaviour:
- Reset (rsta=0, asynchronous): state=IDLE, all pointers, counters and buffer cleared. All outputs are 0: busy, done, err_short, s_tready, m_tvalid, m_tlast, bram_en, bram_we, bram_addr, bram_din, m_tdata. Reset mid-job aborts the job with no done pulse.
- BRAM control outputs are combinational from state and pointers. All other outputs are registered.
- IDLE:
  - start=1: latch len=cfg_len, passes=cfg_passes, clear err_short.
  - len=0 or passes=0: go to DONE.
  - Otherwise: go to FILL.
  - start while busy is ignored.
- FILL:
  - s_tready=1.
  - Each handshake: bram_en=1, bram_we=1, bram_addr=wr_ptr, bram_din=s_tdata, then wr_ptr++.
  - Word number len accepted: eff_len=len, go to DRAIN.
  - s_tlast on word k<len: eff_len=k, err_short=1, go to DRAIN.
  - s_tlast absent on word len: no error.
  - s_tready drops in the cycle after the final accepted word.
- DRAIN read issue:
  - Issue a read (bram_en=1, bram_we=0, bram_addr=rd_ptr) only while buf_count + inflight < 2. inflight is 1 for the cycle after an issue.
  - rd_ptr wraps eff_len-1 -> 0 and increments pass_cnt.
  - Issue stops after word eff_len-1 of pass passes-1.
  - Returned bram_dout is written into the 2-entry buffer. The buffer head drives m_tdata/m_tvalid.
  - A word pops on m_tvalid & m_tready. Push and pop in the same cycle are legal.
  - m_tdata is held stable while m_tvalid=1 and m_tready=0.
  - m_tlast travels with its word as a buffer tag.
- DRAIN timing:
  - First read is issued in the DRAIN-entry cycle T.
  - First m_tvalid is in cycle T+2.
  - With m_tready held high, one word per cycle with no bubbles, including across pass wrap.
  - Total words output = eff_len*passes.
- DONE:
  - Entered from DRAIN when all reads are issued, inflight=0 and the buffer is empty.
  - done=1 for exactly 1 cycle, then IDLE. busy drops in the IDLE cycle.
- Widths: eff_len ≤ DEPTH. pass_cnt is PASS_W bits and compares with latched passes, never wrapping.

Test Plan:
- Basic: start, cfg_len=11, cfg_passes=1; 11 words 0x..00..0x..0A streamed with s_tvalid held high, s_tlast on word 11. Required: 11 BRAM writes at addr 0..10; m_tvalid first high 2 cycles after DRAIN entry; output 0..0x0A on 11 consecutive cycles; m_tlast only on 0x0A; done 1 cycle later; err_short=0.
- Replay: cfg_len=3, cfg_passes=4, data A,B,C. Required: 12 output words ABCABCABCABC, back-to-back; m_tlast on every C.
- Backpressure: same as Replay with m_tready toggled 1,0,0,1 repeating. Required: no word lost or duplicated; m_tdata stable while stalled; at most 2 reads outstanding into the buffer.
- Short stream: cfg_len=8, s_tlast on word 5. Required: err_short=1; eff_len=5; 5 words per pass; err_short cleared by the next start.
- Degenerate/ignored start: cfg_passes=0. Required: no BRAM access, done pulse 1 cycle after start. A start pulse issued mid-DRAIN has no effect on the current job.
- Reset mid-DRAIN (rsta low for 1 cycle). Required: all outputs 0 immediately, no done pulse; a fresh job afterwards completes correctly.
